prbs7_checker: RTL and testbench

//   Bit-serial PRBS7 receiver/checker: consumes the serial stream of the team's pseudo-random

---
 rtl/prbs_pkg.sv | 25 ++
 rtl/prbs7_checker.sv | 147 ++++++++++++++
 tb/tb_prbs7_checker.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// ============================================================================
// Module   : prbs_pkg
// Purpose  : Shared PRBS7 definitions for the stream generator and checker.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package prbs_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_t;

  localparam int PRBS7_W = 7;

  // x^7 + x^6 + 1, Fibonacci form: next bit is the XOR of the two oldest taps.
  function automatic logic prbs7_fb(input logic [PRBS7_W-1:0] s);
    return s[6] ^ s[5];
  endfunction

endpackage

`default_nettype wire

// File: rtl/prbs7_checker.sv
// ============================================================================
// Module   : prbs7_checker
// Purpose  : Bit-serial PRBS7 checker; self-seeds, locks, counts bit errors.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prbs7_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] bits_cnt
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_CNT - 1);
  localparam logic [ERR_W-1:0]  CNT_MAX   = '1;

  prbs_state_t          state_q, state_d;
  logic [PRBS7_W-1:0]   lfsr_q, lfsr_d;
  logic [2:0]           seed_cnt_q, seed_cnt_d;
  logic [GOOD_W-1:0]    good_q, good_d;
  logic [BAD_W-1:0]     bad_q, bad_d;
  logic                 pulse_q, pulse_d;
  logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0]     bits_cnt_q, bits_cnt_d;
  logic                 exp_bit;
  logic                 err_inc;
  logic                 bits_inc;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    seed_cnt_d = seed_cnt_q;
    good_d     = good_q;
    bad_d      = bad_q;
    pulse_d    = 1'b0;
    err_inc    = 1'b0;
    bits_inc   = 1'b0;
    exp_bit    = prbs7_fb(lfsr_q);

    if (bit_valid) begin
      unique case (state_q)
        SEED: begin
          lfsr_d = {lfsr_q[5:0], bit_in};
          if (seed_cnt_q == 3'd6) begin
            // An all-zero seed is the illegal LFSR state, so keep seeding.
            seed_cnt_d = 3'd0;
            if (lfsr_d != '0) begin
              state_d = VERIFY;
              good_d  = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 3'd1;
          end
        end
        VERIFY: begin
          lfsr_d = {lfsr_q[5:0], exp_bit};
          if (bit_in == exp_bit) begin
            if (good_q == GOOD_LAST) begin
              state_d = LOCKED;
              bad_d   = '0;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else begin
            state_d    = SEED;
            seed_cnt_d = 3'd0;
          end
        end
        LOCKED: begin
          // Feeding back the expected bit keeps one line error from smearing.
          lfsr_d   = {lfsr_q[5:0], exp_bit};
          bits_inc = 1'b1;
          if (bit_in != exp_bit) begin
            pulse_d = 1'b1;
            err_inc = 1'b1;
            if (bad_q == BAD_LAST) begin
              state_d    = SEED;
              seed_cnt_d = 3'd0;
            end else begin
              bad_d = bad_q + BAD_W'(1);
            end
          end else begin
            bad_d = '0;
          end
        end
        default: begin
          state_d    = SEED;
          seed_cnt_d = 3'd0;
        end
      endcase
    end

    err_cnt_d  = err_clr ? '0 : err_cnt_q;
    bits_cnt_d = err_clr ? '0 : bits_cnt_q;
    if (err_inc && (err_cnt_d != CNT_MAX)) begin
      err_cnt_d = err_cnt_d + ERR_W'(1);
    end
    if (bits_inc && (bits_cnt_d != CNT_MAX)) begin
      bits_cnt_d = bits_cnt_d + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEED;
      lfsr_q     <= '0;
      seed_cnt_q <= 3'd0;
      good_q     <= '0;
      bad_q      <= '0;
      pulse_q    <= 1'b0;
      err_cnt_q  <= '0;
      bits_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seed_cnt_q <= seed_cnt_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      pulse_q    <= pulse_d;
      err_cnt_q  <= err_cnt_d;
      bits_cnt_q <= bits_cnt_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err_pulse = pulse_q;
  assign err_cnt   = err_cnt_q;
  assign bits_cnt  = bits_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prbs7_checker.sv
// ============================================================================
// Module   : tb_prbs7_checker
// Purpose  : Scoreboard bench for prbs7_checker (ERR_W=16 and ERR_W=4 copies).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prbs7_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        err_clr = 1'b0;
  logic        locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_cnt, bits_cnt;
  logic [3:0]  err_cnt4, bits_cnt4;

  always #5 clk = ~clk;

  prbs7_checker dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bits_cnt(bits_cnt)
  );

  prbs7_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .err_clr(err_clr),
    .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4), .bits_cnt(bits_cnt4)
  );

  typedef struct {
    bit lk;
    bit pl;
    int e16;
    int b16;
    int e4;
    int b4;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the stream as a bit history obeying b[n] = b[n-7] ^ b[n-6].
  int m_mode;            // 0 = acquiring seed, 1 = confirming, 2 = in lock
  bit m_hist[$];
  int m_nseed, m_good, m_bad;
  int m_e16, m_b16, m_e4, m_b4;
  bit m_pulse;

  task automatic model_reset();
    m_mode = 0;
    m_hist = {};
    for (int i = 0; i < 7; i++) m_hist.push_back(1'b0);
    m_nseed = 0; m_good = 0; m_bad = 0;
    m_e16 = 0; m_b16 = 0; m_e4 = 0; m_b4 = 0;
    m_pulse = 1'b0;
  endtask

  task automatic bump(input bit clr, input bit inc, input int maxv, inout int c);
    if (clr) c = 0;
    if (inc && c < maxv) c = c + 1;
  endtask

  task automatic model_step(input bit v, input bit b, input bit clr);
    bit pred, nz, inc_e, inc_b;
    inc_e = 0; inc_b = 0; m_pulse = 0;
    if (v) begin
      pred = m_hist[0] ^ m_hist[1];
      if (m_mode == 0) begin
        m_hist.push_back(b); void'(m_hist.pop_front());
        m_nseed++;
        if (m_nseed == 7) begin
          m_nseed = 0;
          nz = 0;
          foreach (m_hist[i]) nz |= m_hist[i];
          if (nz) begin m_mode = 1; m_good = 0; end
        end
      end else begin
        m_hist.push_back(pred); void'(m_hist.pop_front());
        if (m_mode == 1) begin
          if (b == pred) begin
            m_good++;
            if (m_good == 16) begin m_mode = 2; m_bad = 0; end
          end else begin
            m_mode = 0; m_nseed = 0;
          end
        end else begin
          inc_b = 1;
          if (b != pred) begin
            m_pulse = 1; inc_e = 1; m_bad++;
            if (m_bad == 4) begin m_mode = 0; m_nseed = 0; end
          end else begin
            m_bad = 0;
          end
        end
      end
    end
    bump(clr, inc_e, 65535, m_e16);
    bump(clr, inc_b, 65535, m_b16);
    bump(clr, inc_e, 15, m_e4);
    bump(clr, inc_b, 15, m_b4);
  endtask

  // Transmit-side PRBS7 source, seeded 7'h01 (bits sent MSB first).
  bit tx_h[$];
  int tx_n;

  task automatic tx_restart();
    tx_h = {};
    tx_n = 0;
  endtask

  task automatic tx_next(output bit b);
    logic [6:0] seed;
    seed = 7'h01;
    if (tx_n < 7) b = seed[6 - tx_n];
    else          b = tx_h[0] ^ tx_h[1];
    tx_h.push_back(b);
    if (tx_h.size() > 7) void'(tx_h.pop_front());
    tx_n++;
  endtask

  task automatic step(input bit v, input bit b, input bit clr, input bit r);
    exp_t e;
    rst = r; bit_valid = v; bit_in = b; err_clr = clr;
    if (r) model_reset();
    else   model_step(v, b, clr);
    e.lk = (m_mode == 2); e.pl = m_pulse;
    e.e16 = m_e16; e.b16 = m_b16; e.e4 = m_e4; e.b4 = m_b4;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic bitx(input bit inv, input bit clr);
    bit b;
    tx_next(b);
    step(1'b1, b ^ inv, clr, 1'b0);
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) bitx(1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("locked",    32'(locked),    32'(e.lk));
      chk("err_pulse", 32'(err_pulse), 32'(e.pl));
      chk("err_cnt",   32'(err_cnt),   32'(e.e16));
      chk("bits_cnt",  32'(bits_cnt),  32'(e.b16));
      chk("err_cnt4",  32'(err_cnt4),  32'(e.e4));
      chk("bits_cnt4", 32'(bits_cnt4), 32'(e.b4));
      chk("locked4",   32'(locked4),   32'(e.lk));
    end
  end

  initial begin
    int vcount;
    int wait_cyc;
    model_reset();
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_err", 32'(err_cnt), 0);

    // Clean stream: lock after 7 seed + 16 verify bits.
    tx_restart();
    clean(22);
    chk("prelock_22", 32'(locked), 0);
    clean(1);
    chk("lock_at_23", 32'(locked), 1);
    clean(500);
    chk("bits_500", 32'(bits_cnt), 500);
    chk("err_500", 32'(err_cnt), 0);

    // Single inverted bit.
    bitx(1'b1, 1'b0);
    chk("single_pulse", 32'(err_pulse), 1);
    chk("single_err", 32'(err_cnt), 1);
    chk("single_lock", 32'(locked), 1);
    clean(20);
    chk("no_propagate", 32'(err_cnt), 1);

    // Four consecutive inversions drop lock; clean stream relocks after 23 bits.
    bitx(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) bitx(1'b1, 1'b0);
    chk("loss_err4", 32'(err_cnt), 4);
    chk("loss_unlock", 32'(locked), 0);
    clean(22);
    chk("relock_22", 32'(locked), 0);
    clean(1);
    chk("relock_23", 32'(locked), 1);

    // All-zero stream never leaves seeding.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("zero_lock", 32'(locked), 0);
    chk("zero_err", 32'(err_cnt), 0);

    // Random valid gaps: lock point counted in valid bits only.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    tx_restart();
    vcount = 0;
    while (vcount < 23) begin
      if ($urandom_range(0, 2) == 0) begin
        idle();
      end else begin
        bitx(1'b0, 1'b0);
        vcount++;
        chk("gap_lock", 32'(locked), 32'(vcount >= 23));
      end
    end
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 2) == 0) idle();
      else bitx(1'b0, 1'b0);
    end

    // Isolated errors saturate the narrow counter.
    for (int i = 0; i < 20; i++) begin
      bitx(1'b1, 1'b0);
      clean(5);
    end
    chk("sat_err16", 32'(err_cnt), 20);
    chk("sat_err4", 32'(err_cnt4), 15);
    bitx(1'b1, 1'b1);
    chk("clr_on_err16", 32'(err_cnt), 1);
    chk("clr_on_err4", 32'(err_cnt4), 1);

    // Random mix of gaps, errors and clears.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else bitx(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 99) == 0));
    end
    clean(30);
    chk("pre_rst_lock", 32'(locked), 1);

    // Reset while locked, right after an error.
    bitx(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_lock", 32'(locked), 0);
    chk("rst_pulse", 32'(err_pulse), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_bits", 32'(bits_cnt), 0);

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(negedge clk); #1;
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
